// File: rtl/hazard_pkg.sv
// -----------------------------------------------------------------------------
// hazard_pkg
// Shared types and constants for the pipeline hazard unit:
//   - mult_state_t     : state encoding of the multu busy tracker
//   - FWD_RF/WB/MEM    : EX operand mux select codes
//   - MULT_CYCLES_DEF  : default multu execute latency
//   - CNT_W            : width of the multiply latency counter (latency <= 15)
//   - fwd_sel()        : EX forwarding priority (MEM over WB, r0 never forwarded)
// -----------------------------------------------------------------------------
package hazard_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } mult_state_t;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

   localparam int MULT_CYCLES_DEF = 4;
   localparam int CNT_W           = 4;

   // MEM holds the younger result, so it wins over WB when both match.
   function automatic logic [1:0] fwd_sel(
      input logic [4:0] src,
      input logic [4:0] wa_m,
      input logic       we_m,
      input logic [4:0] wa_w,
      input logic       we_w
   );
      logic [1:0] sel;
      sel = FWD_RF;
      if (we_m && (wa_m != 5'd0) && (wa_m == src))
         sel = FWD_MEM;
      else if (we_w && (wa_w != 5'd0) && (wa_w == src))
         sel = FWD_WB;
      return sel;
   endfunction

endpackage

// File: rtl/mult_busy_tracker.sv
// -----------------------------------------------------------------------------
// mult_busy_tracker
// Tracks an in-flight multu. A multu in EX starts a countdown of MULT_CYCLES
// cycles during which HI/LO are not yet valid.
// Ports:
//   clk       in  : clock, rising edge
//   rst       in  : synchronous active-high reset (returns to IDLE, clears count)
//   multu_enE in  : a multu is in the EX stage this cycle
//   hilo_busy out : high exactly while the FSM is in BUSY
// -----------------------------------------------------------------------------
module mult_busy_tracker
   import hazard_pkg::*;
#(
   parameter int MULT_CYCLES = MULT_CYCLES_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic multu_enE,
   output logic hilo_busy
);

   mult_state_t        r_state;
   logic [CNT_W-1:0]   r_cnt;
   mult_state_t        w_state_nxt;
   logic [CNT_W-1:0]   w_cnt_nxt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Loading MULT_CYCLES-1 and leaving on zero gives MULT_CYCLES busy cycles.
   // A new multu_enE while already BUSY is ignored.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         ST_IDLE: begin
            if (multu_enE) begin
               w_state_nxt = ST_BUSY;
               w_cnt_nxt   = CNT_W'(MULT_CYCLES - 1);
            end
         end
         ST_BUSY: begin
            if (r_cnt == '0) begin
               w_state_nxt = ST_IDLE;
            end else begin
               w_cnt_nxt = r_cnt - CNT_W'(1);
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   assign hilo_busy = (r_state == ST_BUSY);

endmodule

// File: rtl/hazard_unit.sv
// -----------------------------------------------------------------------------
// hazard_unit
// Hazard detection and forwarding control for a 5-stage MIPS-style pipeline.
// Configuration macro: HAZARD_FWD_EN
//   defined   : EX and ID-branch forwarding enabled
//   undefined : forward selects tied to 0, and any RAW dependency of the ID
//               sources on an EX or MEM writer stalls instead
// Ports:
//   clk, rst                         : clock, synchronous active-high reset
//   rsD, rtD                         : ID source registers
//   branchD, jumpD, branch_takenD    : ID control-flow flags
//   hilo_readD, multu_enD            : ID reads HI/LO / issues a multu
//   rsE, rtE, wa_E, we_regE, dm2regE : EX sources, destination, write/load
//   multu_enE                        : multu in EX
//   wa_M, we_regM, dm2regM           : MEM destination, write/load
//   wa_W, we_regW                    : WB destination, write
//   stallF, stallD, flushE           : hold PC and IF/ID, bubble ID/EX
//   flushD                           : squash IF/ID on a taken redirect
//   forwardAE, forwardBE             : EX operand select (00 RF, 01 WB, 10 MEM)
//   forwardAD, forwardBD             : ID comparator select (1 = MEM result)
//   hilo_busy                        : a multiply is in flight
// -----------------------------------------------------------------------------
module hazard_unit
   import hazard_pkg::*;
#(
   parameter int MULT_CYCLES = MULT_CYCLES_DEF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [4:0] rsD,
   input  logic [4:0] rtD,
   input  logic       branchD,
   input  logic       jumpD,
   input  logic       branch_takenD,
   input  logic       hilo_readD,
   input  logic       multu_enD,
   input  logic [4:0] rsE,
   input  logic [4:0] rtE,
   input  logic [4:0] wa_E,
   input  logic       we_regE,
   input  logic       dm2regE,
   input  logic       multu_enE,
   input  logic [4:0] wa_M,
   input  logic       we_regM,
   input  logic       dm2regM,
   input  logic [4:0] wa_W,
   input  logic       we_regW,
   output logic       stallF,
   output logic       stallD,
   output logic       flushD,
   output logic       flushE,
   output logic [1:0] forwardAE,
   output logic [1:0] forwardBE,
   output logic       forwardAD,
   output logic       forwardBD,
   output logic       hilo_busy
);

   logic w_e_hit_d;    // EX writer (non-r0) targets an ID source
   logic w_m_hit_d;    // MEM writer target (non-r0) equals an ID source
   logic w_lu_stall;
   logic w_br_stall;
   logic w_hilo_stall;
   logic w_dep_stall;
   logic w_stall;

   mult_busy_tracker #(
      .MULT_CYCLES (MULT_CYCLES)
   ) u_mult_busy (
      .clk       (clk),
      .rst       (rst),
      .multu_enE (multu_enE),
      .hilo_busy (hilo_busy)
   );

   assign w_e_hit_d = (wa_E != 5'd0) && ((wa_E == rsD) || (wa_E == rtD));
   assign w_m_hit_d = (wa_M != 5'd0) && ((wa_M == rsD) || (wa_M == rtD));

   assign w_lu_stall   = dm2regE && we_regE && w_e_hit_d;
   // The branch compares in ID, so an EX result is never ready and a load in
   // MEM is only ready after its data-memory read.
   assign w_br_stall   = branchD && ((we_regE && w_e_hit_d) || (dm2regM && w_m_hit_d));
   assign w_hilo_stall = (hilo_busy && (hilo_readD || multu_enD)) ||
                         (multu_enE && hilo_readD);

`ifdef HAZARD_FWD_EN
   assign w_dep_stall = 1'b0;

   assign forwardAE = rst ? FWD_RF : fwd_sel(rsE, wa_M, we_regM, wa_W, we_regW);
   assign forwardBE = rst ? FWD_RF : fwd_sel(rtE, wa_M, we_regM, wa_W, we_regW);
   assign forwardAD = !rst && we_regM && (wa_M != 5'd0) && (wa_M == rsD);
   assign forwardBD = !rst && we_regM && (wa_M != 5'd0) && (wa_M == rtD);
`else
   logic w_unused_fwd;

   // Without bypass paths the ID instruction waits until every pending
   // producer in EX and MEM has reached WB.
   assign w_dep_stall = (we_regE && w_e_hit_d) || (we_regM && w_m_hit_d);

   assign forwardAE = FWD_RF;
   assign forwardBE = FWD_RF;
   assign forwardAD = 1'b0;
   assign forwardBD = 1'b0;

   assign w_unused_fwd = ^{rsE, rtE, wa_W, we_regW};
`endif

   assign w_stall = !rst && (w_lu_stall || w_br_stall || w_hilo_stall || w_dep_stall);

   assign stallF = w_stall;
   assign stallD = w_stall;
   assign flushE = w_stall;
   // A stalled redirect is replayed next cycle, so it must not squash IF/ID yet.
   assign flushD = !rst && (branch_takenD || jumpD) && !w_stall;

endmodule

// File: tb/tb_hazard_unit.sv
// -----------------------------------------------------------------------------
// tb_hazard_unit
// Directed testbench for hazard_unit with MULT_CYCLES = 4. Expected values
// that depend on HAZARD_FWD_EN are selected from the FWD constant below.
// -----------------------------------------------------------------------------
module tb_hazard_unit;

`ifdef HAZARD_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic       clk;
   logic       rst;
   logic [4:0] rsD, rtD;
   logic       branchD, jumpD, branch_takenD, hilo_readD, multu_enD;
   logic [4:0] rsE, rtE, wa_E;
   logic       we_regE, dm2regE, multu_enE;
   logic [4:0] wa_M;
   logic       we_regM, dm2regM;
   logic [4:0] wa_W;
   logic       we_regW;
   logic       stallF, stallD, flushD, flushE;
   logic [1:0] forwardAE, forwardBE;
   logic       forwardAD, forwardBD;
   logic       hilo_busy;

   int n_chk;
   int n_fail;

   hazard_unit #(
      .MULT_CYCLES (4)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .rsD           (rsD),
      .rtD           (rtD),
      .branchD       (branchD),
      .jumpD         (jumpD),
      .branch_takenD (branch_takenD),
      .hilo_readD    (hilo_readD),
      .multu_enD     (multu_enD),
      .rsE           (rsE),
      .rtE           (rtE),
      .wa_E          (wa_E),
      .we_regE       (we_regE),
      .dm2regE       (dm2regE),
      .multu_enE     (multu_enE),
      .wa_M          (wa_M),
      .we_regM       (we_regM),
      .dm2regM       (dm2regM),
      .wa_W          (wa_W),
      .we_regW       (we_regW),
      .stallF        (stallF),
      .stallD        (stallD),
      .flushD        (flushD),
      .flushE        (flushE),
      .forwardAE     (forwardAE),
      .forwardBE     (forwardBE),
      .forwardAD     (forwardAD),
      .forwardBD     (forwardBD),
      .hilo_busy     (hilo_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      rsD = 0; rtD = 0; branchD = 0; jumpD = 0; branch_takenD = 0;
      hilo_readD = 0; multu_enD = 0;
      rsE = 0; rtE = 0; wa_E = 0; we_regE = 0; dm2regE = 0; multu_enE = 0;
      wa_M = 0; we_regM = 0; dm2regM = 0;
      wa_W = 0; we_regW = 0;
   endtask

   task automatic test_reset();
      clear_inputs();
      rst = 1'b1;
      // Hazards and forwards everywhere, plus a multu: all must be masked.
      dm2regE = 1; we_regE = 1; wa_E = 5'd3; rsD = 5'd3; rtD = 5'd4;
      we_regM = 1; wa_M = 5'd4; rsE = 5'd4; rtE = 5'd4;
      branch_takenD = 1; multu_enE = 1; hilo_readD = 1;
      step();
      step();
      n_chk++; if (stallF !== 1'b0) begin n_fail++; $display("FAIL rst_stallF: got %b expected 0", stallF); end
      n_chk++; if (stallD !== 1'b0) begin n_fail++; $display("FAIL rst_stallD: got %b expected 0", stallD); end
      n_chk++; if (flushD !== 1'b0) begin n_fail++; $display("FAIL rst_flushD: got %b expected 0", flushD); end
      n_chk++; if (flushE !== 1'b0) begin n_fail++; $display("FAIL rst_flushE: got %b expected 0", flushE); end
      n_chk++; if (forwardAE !== 2'b00) begin n_fail++; $display("FAIL rst_forwardAE: got %b expected 00", forwardAE); end
      n_chk++; if (forwardBE !== 2'b00) begin n_fail++; $display("FAIL rst_forwardBE: got %b expected 00", forwardBE); end
      n_chk++; if (forwardBD !== 1'b0) begin n_fail++; $display("FAIL rst_forwardBD: got %b expected 0", forwardBD); end
      n_chk++; if (hilo_busy !== 1'b0) begin n_fail++; $display("FAIL rst_hilo_busy: got %b expected 0", hilo_busy); end
      clear_inputs();
      rst = 1'b0;
      step();
   endtask

   task automatic test_forward();
      logic [1:0] exp;
      clear_inputs();
      // r8 produced in MEM
      we_regM = 1; wa_M = 5'd8; rsE = 5'd8;
      #1;
      exp = FWD ? 2'b10 : 2'b00;
      n_chk++; if (forwardAE !== exp) begin n_fail++; $display("FAIL fwd_mem_AE: got %b expected %b", forwardAE, exp); end
      n_chk++; if (forwardBE !== 2'b00) begin n_fail++; $display("FAIL fwd_mem_BE: got %b expected 00", forwardBE); end
      // r8 only in WB
      we_regM = 0; wa_M = 0; we_regW = 1; wa_W = 5'd8; rtE = 5'd8;
      #1;
      exp = FWD ? 2'b01 : 2'b00;
      n_chk++; if (forwardAE !== exp) begin n_fail++; $display("FAIL fwd_wb_AE: got %b expected %b", forwardAE, exp); end
      n_chk++; if (forwardBE !== exp) begin n_fail++; $display("FAIL fwd_wb_BE: got %b expected %b", forwardBE, exp); end
      // MEM and WB both write r8: MEM wins
      we_regM = 1; wa_M = 5'd8;
      #1;
      exp = FWD ? 2'b10 : 2'b00;
      n_chk++; if (forwardAE !== exp) begin n_fail++; $display("FAIL fwd_prio_AE: got %b expected %b", forwardAE, exp); end
      // r0 never forwarded
      wa_M = 0; wa_W = 0; rsE = 0; rtE = 0;
      #1;
      n_chk++; if (forwardAE !== 2'b00) begin n_fail++; $display("FAIL fwd_r0_AE: got %b expected 00", forwardAE); end
      n_chk++; if (forwardBE !== 2'b00) begin n_fail++; $display("FAIL fwd_r0_BE: got %b expected 00", forwardBE); end
      step();
   endtask

   task automatic test_load_use();
      logic exp;
      clear_inputs();
      // lw r9 in EX, consumer reads r9 as rt in ID
      dm2regE = 1; we_regE = 1; wa_E = 5'd9; rtD = 5'd9;
      #1;
      n_chk++; if (stallF !== 1'b1) begin n_fail++; $display("FAIL lu_stallF: got %b expected 1", stallF); end
      n_chk++; if (stallD !== 1'b1) begin n_fail++; $display("FAIL lu_stallD: got %b expected 1", stallD); end
      n_chk++; if (flushE !== 1'b1) begin n_fail++; $display("FAIL lu_flushE: got %b expected 1", flushE); end
      step();
      // bubble in EX, load now in MEM
      dm2regE = 0; we_regE = 0; wa_E = 0;
      dm2regM = 1; we_regM = 1; wa_M = 5'd9;
      #1;
      exp = FWD ? 1'b0 : 1'b1;
      n_chk++; if (stallF !== exp) begin n_fail++; $display("FAIL lu_next_stallF: got %b expected %b", stallF, exp); end
      step();
      // load now in WB: never a stall
      dm2regM = 0; we_regM = 0; wa_M = 0; we_regW = 1; wa_W = 5'd9;
      #1;
      n_chk++; if (flushE !== 1'b0) begin n_fail++; $display("FAIL lu_wb_flushE: got %b expected 0", flushE); end
      // load to r0 does not stall
      clear_inputs();
      dm2regE = 1; we_regE = 1; wa_E = 5'd0; rsD = 5'd0; rtD = 5'd0;
      #1;
      n_chk++; if (stallF !== 1'b0) begin n_fail++; $display("FAIL lu_r0_stallF: got %b expected 0", stallF); end
      step();
   endtask

   task automatic test_branch();
      logic exp;
      clear_inputs();
      branchD = 1; rsD = 5'd10; rtD = 5'd11;
      we_regE = 1; wa_E = 5'd10;
      #1;
      n_chk++; if (stallF !== 1'b1) begin n_fail++; $display("FAIL br_ex_stall: got %b expected 1", stallF); end
      step();
      we_regE = 0; wa_E = 0;
      we_regM = 1; wa_M = 5'd10; dm2regM = 0;
      #1;
      exp = FWD ? 1'b0 : 1'b1;
      n_chk++; if (stallF !== exp) begin n_fail++; $display("FAIL br_mem_stall: got %b expected %b", stallF, exp); end
      exp = FWD ? 1'b1 : 1'b0;
      n_chk++; if (forwardAD !== exp) begin n_fail++; $display("FAIL br_mem_forwardAD: got %b expected %b", forwardAD, exp); end
      n_chk++; if (forwardBD !== 1'b0) begin n_fail++; $display("FAIL br_mem_forwardBD: got %b expected 0", forwardBD); end
      // a load in MEM feeding the branch still stalls
      dm2regM = 1;
      #1;
      n_chk++; if (stallD !== 1'b1) begin n_fail++; $display("FAIL br_memload_stall: got %b expected 1", stallD); end
      step();
   endtask

   task automatic test_multu();
      int stall_cycles;
      int busy_cycles;
      clear_inputs();
      stall_cycles = 0;
      busy_cycles  = 0;
      multu_enE = 1; hilo_readD = 1;
      #1;
      n_chk++; if (stallF !== 1'b1) begin n_fail++; $display("FAIL mul_issue_stall: got %b expected 1", stallF); end
      n_chk++; if (hilo_busy !== 1'b0) begin n_fail++; $display("FAIL mul_issue_busy: got %b expected 0", hilo_busy); end
      if (stallF === 1'b1) stall_cycles++;
      step();
      multu_enE = 0;
      for (int i = 0; i < 4; i++) begin
         #1;
         n_chk++; if (hilo_busy !== 1'b1) begin n_fail++; $display("FAIL mul_busy_%0d: got %b expected 1", i, hilo_busy); end
         if (stallF === 1'b1) stall_cycles++;
         if (hilo_busy === 1'b1) busy_cycles++;
         step();
      end
      #1;
      n_chk++; if (hilo_busy !== 1'b0) begin n_fail++; $display("FAIL mul_done_busy: got %b expected 0", hilo_busy); end
      n_chk++; if (stallF !== 1'b0) begin n_fail++; $display("FAIL mul_done_stall: got %b expected 0", stallF); end
      n_chk++; if (stall_cycles !== 5) begin n_fail++; $display("FAIL mul_stall_count: got %0d expected 5", stall_cycles); end
      n_chk++; if (busy_cycles !== 4) begin n_fail++; $display("FAIL mul_busy_count: got %0d expected 4", busy_cycles); end
      step();
   endtask

   task automatic test_rst_mid_multu();
      clear_inputs();
      multu_enE = 1;
      step();
      // first BUSY cycle: a second multu in ID must wait
      multu_enE = 0; multu_enD = 1;
      #1;
      n_chk++; if (stallF !== 1'b1) begin n_fail++; $display("FAIL rmid_multuD_stall: got %b expected 1", stallF); end
      multu_enD = 0;
      step();
      // second BUSY cycle: reset arrives
      n_chk++; if (hilo_busy !== 1'b1) begin n_fail++; $display("FAIL rmid_busy2: got %b expected 1", hilo_busy); end
      rst = 1; hilo_readD = 1;
      #1;
      n_chk++; if (stallF !== 1'b0) begin n_fail++; $display("FAIL rmid_rst_stall: got %b expected 0", stallF); end
      step();
      rst = 0;
      #1;
      n_chk++; if (hilo_busy !== 1'b0) begin n_fail++; $display("FAIL rmid_after_busy: got %b expected 0", hilo_busy); end
      n_chk++; if (stallF !== 1'b0) begin n_fail++; $display("FAIL rmid_after_stall: got %b expected 0", stallF); end
      step();
   endtask

   task automatic test_flush_priority();
      clear_inputs();
      branch_takenD = 1;
      dm2regE = 1; we_regE = 1; wa_E = 5'd5; rsD = 5'd5;
      #1;
      n_chk++; if (flushD !== 1'b0) begin n_fail++; $display("FAIL fl_stalled_flushD: got %b expected 0", flushD); end
      n_chk++; if (flushE !== 1'b1) begin n_fail++; $display("FAIL fl_stalled_flushE: got %b expected 1", flushE); end
      step();
      dm2regE = 0; we_regE = 0; wa_E = 0;
      #1;
      n_chk++; if (flushD !== 1'b1) begin n_fail++; $display("FAIL fl_redirect_flushD: got %b expected 1", flushD); end
      n_chk++; if (stallF !== 1'b0) begin n_fail++; $display("FAIL fl_redirect_stall: got %b expected 0", stallF); end
      step();
      branch_takenD = 0; jumpD = 1;
      #1;
      n_chk++; if (flushD !== 1'b1) begin n_fail++; $display("FAIL fl_jump_flushD: got %b expected 1", flushD); end
      jumpD = 0;
      #1;
      n_chk++; if (flushD !== 1'b0) begin n_fail++; $display("FAIL fl_none_flushD: got %b expected 0", flushD); end
      step();
   endtask

   initial begin
      n_chk  = 0;
      n_fail = 0;
      rst    = 1'b1;
      clear_inputs();
      test_reset();
      test_forward();
      test_load_use();
      test_branch();
      test_multu();
      test_rst_mid_multu();
      test_flush_priority();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 4, giving the multu execute latency in cycles (legal range 2..15).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have inputs rsD, rtD, 5 bits each: ID source registers.
REQ-005 SHALL have inputs branchD, jumpD, branch_takenD, hilo_readD, multu_enD, 1 bit each: ID decode flags.
REQ-006 SHALL have inputs rsE, rtE, wa_E, 5 bits each: EX sources and write register.
REQ-007 SHALL have inputs we_regE, dm2regE, multu_enE, 1 bit each: EX controls from the ID/EX register.
REQ-008 SHALL have inputs wa_M (5 bits), we_regM and dm2regM (1 bit each): MEM write-back info.
REQ-009 SHALL have inputs wa_W (5 bits) and we_regW (1 bit): WB write-back info.
REQ-010 SHALL have outputs stallF and stallD (1 bit each): hold the PC and the IF/ID register.
REQ-011 SHALL have outputs flushD and flushE (1 bit each): clear the IF/ID and ID/EX registers.
REQ-012 SHALL have outputs forwardAE and forwardBE (2 bits each): EX operand mux select, 00 = RF, 01 = WB, 10 = MEM.
REQ-013 SHALL have outputs forwardAD and forwardBD (1 bit each): ID branch comparator select, 1 = MEM result.
REQ-014 SHALL have output hilo_busy (1 bit): a multiply is in flight.

Function
REQ-015 forwardAE SHALL be 10 when we_regM, wa_M!=0 and wa_M==rsE; else 01 when we_regW, wa_W!=0 and wa_W==rsE; else 00. forwardBE is identical using rtE.
REQ-016 forwardAD SHALL be 1 when we_regM, wa_M!=0 and wa_M==rsD; forwardBD is identical using rtD.
REQ-017 Load-use stall SHALL assert when dm2regE, we_regE, wa_E!=0 and wa_E equals rsD or rtD.
REQ-018 Branch stall SHALL assert when branchD and either (we_regE, wa_E!=0, wa_E in {rsD,rtD}) or (dm2regM, wa_M!=0, wa_M in {rsD,rtD}).
REQ-019 The multiply FSM SHALL have states IDLE and BUSY; IDLE->BUSY on multu_enE, loading counter = MULT_CYCLES-1.
REQ-020 In BUSY the counter SHALL decrement each cycle; on counter==0 the FSM returns to IDLE in that same clock edge.
REQ-021 hilo_busy SHALL be 1 exactly while state==BUSY, i.e. MULT_CYCLES cycles after the multu_enE cycle.
REQ-022 HI/LO stall SHALL assert when hilo_busy and (hilo_readD or multu_enD), and also when multu_enE and hilo_readD.
REQ-023 Combined stall = OR of REQ-017/018/022; stallF = stallD = flushE = stall; all outputs are combinational apart from the FSM.
REQ-024 flushD SHALL be (branch_takenD or jumpD) and not stall; a stall always wins over a simultaneous redirect.
REQ-025 Register 0 SHALL never cause a forward or a stall.

Reset
REQ-026 On rst the FSM SHALL enter IDLE and the counter clear; hilo_busy = 0 on the following cycle, even mid-multiply.
REQ-027 While rst is high, stallF, stallD, flushD and flushE SHALL be 0 and the forwarding outputs SHALL be 00/0.

Configuration
REQ-028 Macro HAZARD_FWD_EN defined: forwarding per REQ-015/016.
REQ-029 HAZARD_FWD_EN undefined: all forward outputs are tied 0; stall additionally asserts when rsD/rtD (nonzero) matches wa_E with we_regE or wa_M with we_regM; the multiply FSM is unchanged.

Structure
REQ-030 Shared package hazard_pkg SHALL hold the FSM state enum, the FWD_RF/FWD_WB/FWD_MEM constants and the MULT_CYCLES default.
REQ-031 Sub-module mult_busy_tracker SHALL contain the FSM and counter (in: clk, rst, multu_enE; out: hilo_busy).

Verification
REQ-032 add writes r8 in MEM, rsE=8 -> forwardAE=10; r8 in WB only -> forwardAE=01; wa_M=0, rsE=0 -> forwardAE=00.
REQ-033 lw r9 in EX, rtD=9 -> stallF=stallD=flushE=1 for exactly one cycle, then 0.
REQ-034 beq in ID, rsD=10, we_regE with wa_E=10 -> stall=1; the next cycle with wa_M=10 and dm2regM=0 -> stall=0, forwardAD=1.
REQ-035 multu in EX, mfhi follows with MULT_CYCLES=4 -> stall held for 5 cycles, hilo_busy high for 4 cycles.
REQ-036 rst pulsed in the second BUSY cycle -> hilo_busy=0 next cycle, no stall.
REQ-037 branch_takenD=1 with load-use stall -> flushD=0; the next cycle with no stall -> flushD=1.
